// File: rtl/md_issue_ctrl.sv
// D->E issue control for the MulDiv unit: decodes the D-stage op, registers E-stage controls,
// and stalls HI/LO-related ops while a result is outstanding. Optional MDCTRL_SYNC_CHECK_EN adds a Busy cross-check.
//
// state | meaning
// IDLE  | no result outstanding (cnt == 0), MD ops may issue
// WAIT  | mult/div in flight (cnt != 0), every MD op in D is stalled
module md_issue_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] D_MD_Op,
  input  logic       D_Ext_Stall,
  input  logic       E_Flush,
  input  logic       MD_Busy,
  output logic       MD_Stall,
  output logic       E_MD_Start,
  output logic [1:0] E_MD_Type,
  output logic [1:0] E_MD_Write,
  output logic [1:0] E_MD_RdSel,
  output logic       MD_Sync_Err
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES);

  state_t           state, nextState;
  logic [CNT_W-1:0] cnt, cntNext;

  logic       isMdOp, isMulDiv, issue;
  logic       startNext;
  logic [1:0] typeNext, writeNext, rdSelNext;

  always_comb begin
    isMdOp   = (D_MD_Op >= 4'd1) && (D_MD_Op <= 4'd8);
    isMulDiv = (D_MD_Op >= 4'd1) && (D_MD_Op <= 4'd4);
    MD_Stall = isMdOp && (cnt != '0);
    issue    = isMdOp && !MD_Stall && !D_Ext_Stall && !E_Flush;
  end

  // State register, countdown and E-stage control registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      E_MD_Start <= 1'b0;
      E_MD_Type  <= 2'b00;
      E_MD_Write <= 2'b00;
      E_MD_RdSel <= 2'b00;
    end else begin
      state      <= nextState;
      cnt        <= cntNext;
      E_MD_Start <= startNext;
      E_MD_Type  <= typeNext;
      E_MD_Write <= writeNext;
      E_MD_RdSel <= rdSelNext;
    end
  end

  // Next state: the countdown runs regardless of external stalls and saturates at 0.
  always_comb begin
    cntNext = cnt;
    if (issue && isMulDiv) begin
      cntNext = (D_MD_Op <= 4'd2) ? MultLoad : DivLoad;
    end else if (cnt != '0) begin
      cntNext = cnt - 1'b1;
    end
    nextState = (cntNext != '0) ? WAIT : IDLE;
  end

  // Output decode: anything not issued becomes an all-zero bubble in E.
  always_comb begin
    startNext = 1'b0;
    typeNext  = 2'b00;
    writeNext = 2'b00;
    rdSelNext = 2'b00;
    if (issue) begin
      case (D_MD_Op)
        4'd1: begin startNext = 1'b1; typeNext = 2'b00; end
        4'd2: begin startNext = 1'b1; typeNext = 2'b01; end
        4'd3: begin startNext = 1'b1; typeNext = 2'b10; end
        4'd4: begin startNext = 1'b1; typeNext = 2'b11; end
        4'd5: writeNext = 2'b01;
        4'd6: writeNext = 2'b10;
        4'd7: rdSelNext = 2'b01;
        4'd8: rdSelNext = 2'b10;
        default: ;
      endcase
    end
  end

`ifdef MDCTRL_SYNC_CHECK_EN
  // Unit Busy lags Start by one edge, so compare against the countdown delayed by one edge.
  logic [CNT_W-1:0] cntD;
  logic             syncErr;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cntD    <= '0;
      syncErr <= 1'b0;
    end else begin
      cntD <= cnt;
      if (MD_Busy != (cntD != '0)) syncErr <= 1'b1;
    end
  end

  assign MD_Sync_Err = syncErr;
`else
  logic unusedBusy;
  assign unusedBusy  = MD_Busy;
  assign MD_Sync_Err = 1'b0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: single-cycle vector table plus multi-cycle issue/stall sequences.
module tb_md_issue_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [3:0] D_MD_Op;
  logic       D_Ext_Stall, E_Flush, MD_Busy;
  logic       MD_Stall, E_MD_Start, MD_Sync_Err;
  logic [1:0] E_MD_Type, E_MD_Write, E_MD_RdSel;

  int checks   = 0;
  int failures = 0;

  // Simple MulDiv unit model: Busy rises the edge after Start and lasts the op latency.
  int   busyCnt;
  logic forceBusy0 = 1'b0;

  md_issue_ctrl dut (
    .Clk(Clk), .Reset(Reset), .D_MD_Op(D_MD_Op), .D_Ext_Stall(D_Ext_Stall),
    .E_Flush(E_Flush), .MD_Busy(MD_Busy), .MD_Stall(MD_Stall),
    .E_MD_Start(E_MD_Start), .E_MD_Type(E_MD_Type), .E_MD_Write(E_MD_Write),
    .E_MD_RdSel(E_MD_RdSel), .MD_Sync_Err(MD_Sync_Err)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset)                busyCnt <= 0;
    else if (E_MD_Start)       busyCnt <= E_MD_Type[1] ? 10 : 5;
    else if (busyCnt != 0)     busyCnt <= busyCnt - 1;
  end
  assign MD_Busy = (busyCnt != 0) && !forceBusy0;

  typedef struct {
    logic [3:0] op;
    logic       ext;
    logic       fl;
    logic       expStall;
    logic       expStart;
    logic [1:0] expType;
    logic [1:0] expWrite;
    logic [1:0] expRdSel;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0]  = '{4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[1]  = '{4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00};
    vecs[2]  = '{4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00};
    vecs[3]  = '{4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01};
    vecs[4]  = '{4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10};
    vecs[5]  = '{4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[6]  = '{4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[7]  = '{4'd5,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[8]  = '{4'd7,  1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[9]  = '{4'd1,  1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[10] = '{4'd3,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[11] = '{4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00};
    vecs[12] = '{4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01};

    Reset = 1'b0; D_MD_Op = 4'd0; D_Ext_Stall = 1'b0; E_Flush = 1'b0;
    repeat (3) tick();
    chk("rst_start", E_MD_Start, 0);
    chk("rst_stall", MD_Stall, 0);
    chk("rst_syncerr", MD_Sync_Err, 0);
    @(negedge Clk) Reset = 1'b1;
    tick();

    // Single-cycle vectors from IDLE; flushed/stalled mult/div must not load the countdown.
    for (int i = 0; i < 13; i++) begin
      D_MD_Op = vecs[i].op; D_Ext_Stall = vecs[i].ext; E_Flush = vecs[i].fl;
      #1;
      chk($sformatf("vec%0d_stall", i), MD_Stall, vecs[i].expStall);
      tick();
      chk($sformatf("vec%0d_start", i), E_MD_Start, vecs[i].expStart);
      chk($sformatf("vec%0d_type", i), E_MD_Type, vecs[i].expType);
      chk($sformatf("vec%0d_write", i), E_MD_Write, vecs[i].expWrite);
      chk($sformatf("vec%0d_rdsel", i), E_MD_RdSel, vecs[i].expRdSel);
    end
    D_Ext_Stall = 1'b0; E_Flush = 1'b0;

    // mult then dependent mfhi: 5 stall cycles, mfhi enters E at e6.
    D_MD_Op = 4'd1;
    tick();
    chk("A_start", E_MD_Start, 1);
    chk("A_type", E_MD_Type, 0);
    D_MD_Op = 4'd7;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!MD_Stall) break;
      chk("A_startPulse", E_MD_Start, (i == 0) ? 1 : 0);
      chk("A_bubbleRd", E_MD_RdSel, 0);
      n++;
      tick();
    end
    chk("A_stallCycles", n, 5);
    tick();
    chk("A_mfhiRd", E_MD_RdSel, 1);
    chk("A_mfhiStart", E_MD_Start, 0);

    // divu then mflo, external stall during WAIT must not freeze the countdown.
    D_MD_Op = 4'd4;
    tick();
    chk("B_start", E_MD_Start, 1);
    chk("B_type", E_MD_Type, 3);
    D_MD_Op = 4'd8;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      D_Ext_Stall = (i < 3);
      #1;
      if (!MD_Stall) break;
      n++;
      tick();
    end
    D_Ext_Stall = 1'b0;
    chk("B_stallCycles", n, 10);
    tick();
    chk("B_mfloRd", E_MD_RdSel, 2);
    chk("B_mfloType", E_MD_Type, 0);

    // div, reset with cnt=7: everything clears immediately.
    D_MD_Op = 4'd3;
    tick();
    chk("C_type", E_MD_Type, 2);
    D_MD_Op = 4'd0;
    repeat (3) tick();
    D_MD_Op = 4'd3;
    #1;
    chk("C_preStall", MD_Stall, 1);
    Reset = 1'b0;
    #1;
    chk("C_rstStall", MD_Stall, 0);
    chk("C_rstStart", E_MD_Start, 0);
    chk("C_rstType", E_MD_Type, 0);
    chk("C_rstWrite", E_MD_Write, 0);
    chk("C_rstRdSel", E_MD_RdSel, 0);
    chk("C_rstSyncErr", MD_Sync_Err, 0);
    D_MD_Op = 4'd0;
    @(negedge Clk) Reset = 1'b1;
    tick();
    D_MD_Op = 4'd5;
    #1;
    chk("C_postStall", MD_Stall, 0);
    tick();
    chk("C_mthiWrite", E_MD_Write, 1);
    D_MD_Op = 4'd0;
    Reset = 1'b0;
    #1;
    chk("C_rstWriteAsync", E_MD_Write, 0);
    @(negedge Clk) Reset = 1'b1;
    tick();

    // mthi then mfhi back to back with no stall.
    D_MD_Op = 4'd5;
    tick();
    chk("E_write", E_MD_Write, 1);
    D_MD_Op = 4'd7;
    #1;
    chk("E_noStall", MD_Stall, 0);
    tick();
    chk("E_rdSel", E_MD_RdSel, 1);
    chk("E_writeClr", E_MD_Write, 0);
    D_MD_Op = 4'd0;
    repeat (2) tick();
    chk("syncErrClean", MD_Sync_Err, 0);

`ifdef MDCTRL_SYNC_CHECK_EN
    forceBusy0 = 1'b1;
    D_MD_Op = 4'd1;
    tick();
    D_MD_Op = 4'd0;
    tick();
    chk("F_errE1", MD_Sync_Err, 0);
    tick();
    chk("F_errE2", MD_Sync_Err, 1);
    forceBusy0 = 1'b0;
    repeat (8) tick();
    chk("F_errSticky", MD_Sync_Err, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
